// File: rtl/exc_flush_ctrl.sv
// Exception/flush sequencer: arbitrates MEM-stage slot events, pulses CSR commits, holds flush+redirect.
// Latency: event sampled at edge N -> pulses in cycle N+1, flush for FLUSH_CYCLES cycles; no backpressure, MEM is squashed while busy.
module exc_flush_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [6:0]  ECODE_INT    = 7'h00
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_valid_a,
    input  logic        mem_valid_b,
    input  logic        ecode_we_a,
    input  logic        ecode_we_b,
    input  logic [6:0]  ecode_a,
    input  logic [6:0]  ecode_b,
    input  logic        badv_we_a,
    input  logic        badv_we_b,
    input  logic [31:0] badv_a,
    input  logic [31:0] badv_b,
    input  logic [31:0] pc_a,
    input  logic [31:0] pc_b,
    input  logic        ertn_b,
    input  logic        csr_we_b,
    input  logic        idle_b,
    input  logic        int_pending,
    input  logic [31:0] eentry,
    input  logic [31:0] era,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        exc_we,
    output logic [6:0]  exc_ecode,
    output logic [31:0] exc_era,
    output logic        badv_we,
    output logic [31:0] badv_out,
    output logic        ertn_we,
    output logic        idle_state
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_IDLE} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic [31:0] redirect_q, redirect_d;
    logic        exc_we_q, exc_we_d;
    logic [6:0]  ecode_q, ecode_d;
    logic [31:0] era_q, era_d;
    logic        badv_we_q, badv_we_d;
    logic [31:0] badv_q, badv_d;
    logic        ertn_we_q, ertn_we_d;
    logic        idle_q, idle_d;
    logic        to_idle_q, to_idle_d;
    logic [31:0] idle_pc_q, idle_pc_d;
    logic [31:0] pc_b_inc;
    logic        take;

    assign pc_b_inc = pc_b + 32'd4;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_d    = flush_q;
        redirect_d = redirect_q;
        exc_we_d   = 1'b0;
        ecode_d    = ecode_q;
        era_d      = era_q;
        badv_we_d  = 1'b0;
        badv_d     = badv_q;
        ertn_we_d  = 1'b0;
        idle_d     = idle_q;
        to_idle_d  = to_idle_q;
        idle_pc_d  = idle_pc_q;
        take       = 1'b0;
        case (state_q)
            S_RUN: begin
                take      = 1'b1;
                to_idle_d = 1'b0;
                if (int_pending && (mem_valid_a || mem_valid_b)) begin
                    exc_we_d   = 1'b1;
                    ecode_d    = ECODE_INT;
                    era_d      = mem_valid_a ? pc_a : pc_b;
                    redirect_d = eentry;
                end else if (mem_valid_a && ecode_we_a) begin
                    exc_we_d   = 1'b1;
                    ecode_d    = ecode_a;
                    era_d      = pc_a;
                    badv_we_d  = badv_we_a;
                    if (badv_we_a) badv_d = badv_a;
                    redirect_d = eentry;
                end else if (mem_valid_b && ecode_we_b) begin
                    exc_we_d   = 1'b1;
                    ecode_d    = ecode_b;
                    era_d      = pc_b;
                    badv_we_d  = badv_we_b;
                    if (badv_we_b) badv_d = badv_b;
                    redirect_d = eentry;
                end else if (mem_valid_b && ertn_b) begin
                    ertn_we_d  = 1'b1;
                    redirect_d = era;
                end else if (mem_valid_b && csr_we_b) begin
                    redirect_d = pc_b_inc;
                end else if (mem_valid_b && idle_b) begin
                    redirect_d = pc_b_inc;
                    to_idle_d  = 1'b1;
                    idle_pc_d  = pc_b_inc;
                end else begin
                    take = 1'b0;
                end
                if (take) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_LOAD;
                    flush_d = 1'b1;
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    flush_d = 1'b0;
                    idle_d  = to_idle_q;
                    state_d = to_idle_q ? S_IDLE : S_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_IDLE: begin
                // Wake re-enters FLUSH with to_idle cleared so it drains back to RUN.
                if (int_pending) begin
                    exc_we_d   = 1'b1;
                    ecode_d    = ECODE_INT;
                    era_d      = idle_pc_q;
                    redirect_d = eentry;
                    flush_d    = 1'b1;
                    idle_d     = 1'b0;
                    to_idle_d  = 1'b0;
                    cnt_d      = CNT_LOAD;
                    state_d    = S_FLUSH;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_RUN;
            cnt_q      <= '0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
            exc_we_q   <= 1'b0;
            ecode_q    <= '0;
            era_q      <= '0;
            badv_we_q  <= 1'b0;
            badv_q     <= '0;
            ertn_we_q  <= 1'b0;
            idle_q     <= 1'b0;
            to_idle_q  <= 1'b0;
            idle_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            exc_we_q   <= exc_we_d;
            ecode_q    <= ecode_d;
            era_q      <= era_d;
            badv_we_q  <= badv_we_d;
            badv_q     <= badv_d;
            ertn_we_q  <= ertn_we_d;
            idle_q     <= idle_d;
            to_idle_q  <= to_idle_d;
            idle_pc_q  <= idle_pc_d;
        end
    end

    assign flush       = flush_q;
    assign redirect_pc = redirect_q;
    assign exc_we      = exc_we_q;
    assign exc_ecode   = ecode_q;
    assign exc_era     = era_q;
    assign badv_we     = badv_we_q;
    assign badv_out    = badv_q;
    assign ertn_we     = ertn_we_q;
    assign idle_state  = idle_q;

endmodule
